host_rd_engine: RTL and testbench

Parametrised DDR-to-host readout engine; successor of the single-burst PipeOut readout path.
- Issues multi-burst MIG read commands for a byte-counted region.
- Flow-controls on a credit scheme covering downstream buffer fill plus in-flight reads.
- Forwards returned data to the downstream PipeOut FIFO write port.
- Provides busy, complete and abort status; single clock domain (MIG UI clock).

---
 rtl/host_rd_engine_if.sv | 37 +++
 rtl/host_rd_engine.sv | 201 ++++++++++++++++++++
 tb/tb_host_rd_engine.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_rd_engine_if.sv
// ============================================================================
// host_rd_engine_if
//   Bus bundle between the readout engine, the MIG read port and the
//   downstream PipeOut FIFO write port.
//   master : engine side    slave : memory / FIFO side
//   Rev 1.0
// ============================================================================
`default_nettype none

interface host_rd_engine_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 128,
  parameter int OB_CNT_W   = 10
);
  // MIG read command / return channel
  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_ack;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_data_valid;
  // Downstream FIFO write port
  logic [OB_CNT_W-1:0]   ob_count;
  logic                  ob_wr_en;
  logic [DATA_WIDTH-1:0] ob_din;

  modport master (
    output mem_rd_req, mem_rd_addr, ob_wr_en, ob_din,
    input  mem_rd_ack, mem_rd_data, mem_rd_data_valid, ob_count
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, ob_wr_en, ob_din,
    output mem_rd_ack, mem_rd_data, mem_rd_data_valid, ob_count
  );
endinterface

`default_nettype wire

// File: rtl/host_rd_engine.sv
// ============================================================================
// host_rd_engine
//   DDR-to-host readout engine. Splits a byte-counted region into MIG read
//   bursts, throttles issue on a credit covering FIFO fill plus in-flight
//   reads, and forwards returned words to the PipeOut FIFO.
//   Optional: define HOST_RD_RING_EN for ring-buffer address wrapping
//   between ring_base and ring_limit.
//   Rev 1.0
// ============================================================================
`default_nettype none

module host_rd_engine #(
  parameter int ADDR_WIDTH      = 29,
  parameter int DATA_WIDTH      = 128,
  parameter int BURST_BYTES     = 16,
  parameter int ADDR_INCR       = 8,
  parameter int OB_DEPTH        = 512,
  parameter int OB_MARGIN       = 8,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_WIDTH       = 32,
  localparam int OB_CNT_W       = $clog2(OB_DEPTH) + 1,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset_clk,
  input  wire logic                  readout_start,
  input  wire logic                  readout_abort,
  input  wire logic [ADDR_WIDTH-1:0] readout_addr,
  input  wire logic [CNT_WIDTH-1:0]  readout_count,
  output logic                       readout_busy,
  output logic                       readout_complete,
  output logic [OUT_W-1:0]           outstanding,
`ifdef HOST_RD_RING_EN
  input  wire logic [ADDR_WIDTH-1:0] ring_base,
  input  wire logic [ADDR_WIDTH-1:0] ring_limit,
`endif
  host_rd_engine_if.master           bus
);

  localparam int SHIFT = $clog2(BURST_BYTES);
  // One spare bit so the rounded-up burst count can never overflow
  localparam int BL_W  = CNT_WIDTH + 1;
  // Credit arithmetic width: wide enough that fill + in-flight + margin
  // cannot wrap for any legal parameter set
  localparam int CR_W  = ((CNT_WIDTH > 32) ? CNT_WIDTH : 32) + 2;
  localparam logic [CNT_WIDTH-1:0] C_LOW_MASK = CNT_WIDTH'(BURST_BYTES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_ABORT    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BL_W-1:0]       bursts_q, bursts_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  complete_q, complete_d;
  logic                  ob_wr_en_q;
  logic [DATA_WIDTH-1:0] ob_din_q;

  logic                  req_w;
  logic                  ack_take;
  logic                  rtn_take;
  logic [BL_W-1:0]       start_bursts;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  credit_now;
  logic                  credit_after;

  // Credit test: room in the FIFO for everything already in flight plus
  // the safety margin, and the command window not yet full.
  function automatic logic credit_ok(input logic [OB_CNT_W-1:0] fill,
                                     input logic [OUT_W-1:0]    inflight);
    logic [CR_W-1:0] need;
    need = CR_W'(fill) + CR_W'(inflight) + CR_W'(OB_MARGIN);
    return (need < CR_W'(OB_DEPTH)) &&
           (CR_W'(inflight) < CR_W'(MAX_OUTSTANDING));
  endfunction

  // An ack only exists while a command is presented; a return with nothing
  // in flight is treated as stray and never drives the counter negative.
  assign ack_take = (state_q == S_WAIT_ACK) && bus.mem_rd_ack;
  assign rtn_take = bus.mem_rd_data_valid && (out_q != '0);

  // Burst count rounded up: a partial tail still costs a full burst
  assign start_bursts = (BL_W'(readout_count) >> SHIFT) +
                        BL_W'(|(readout_count & C_LOW_MASK));

  assign addr_inc = addr_q + ADDR_WIDTH'(ADDR_INCR);
`ifdef HOST_RD_RING_EN
  assign addr_next = (addr_inc >= ring_limit) ? ring_base : addr_inc;
`else
  assign addr_next = addr_inc;
`endif

  // Back-to-back decision uses the in-flight count as it will be after
  // this cycle's ack and return.
  assign credit_now   = credit_ok(bus.ob_count, out_q);
  assign credit_after = credit_ok(bus.ob_count, out_d);

  // In-flight command counter next value
  always_comb begin
    out_d = out_q;
    case ({ack_take, rtn_take})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
  end

  // Address and remaining-burst bookkeeping
  always_comb begin
    addr_d   = addr_q;
    bursts_d = bursts_q;
    if ((state_q == S_IDLE) && readout_start) begin
      addr_d   = readout_addr;
      bursts_d = start_bursts;
    end else if (ack_take) begin
      addr_d   = addr_next;
      bursts_d = bursts_q - BL_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (readout_start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (readout_abort)             state_d = S_ABORT;
        else if (bursts_q == '0)       state_d = S_DRAIN;
        else if (credit_now)           state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (readout_abort) begin
          state_d = S_ABORT;
        end else if (ack_take) begin
          if ((bursts_q > BL_W'(1)) && credit_after) state_d = S_WAIT_ACK;
          else                                       state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (readout_abort)      state_d = S_ABORT;
        else if (out_q == '0)   state_d = S_IDLE;
      end
      S_ABORT: begin
        if (out_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request is a pure function of state so it drops as soon
  // as the FSM leaves WAIT_ACK
  always_comb begin
    readout_busy = (state_q != S_IDLE);
    req_w        = (state_q == S_WAIT_ACK);
    complete_d   = (state_q == S_DRAIN) && !readout_abort && (out_q == '0);
  end

  // Datapath registers and the one-cycle data forward into the FIFO
  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      addr_q     <= '0;
      bursts_q   <= '0;
      out_q      <= '0;
      complete_q <= 1'b0;
      ob_wr_en_q <= 1'b0;
      ob_din_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      bursts_q   <= bursts_d;
      out_q      <= out_d;
      complete_q <= complete_d;
      ob_wr_en_q <= bus.mem_rd_data_valid;
      ob_din_q   <= bus.mem_rd_data;
    end
  end

  assign readout_complete = complete_q;
  assign outstanding      = out_q;
  assign bus.mem_rd_req   = req_w;
  assign bus.mem_rd_addr  = addr_q;
  assign bus.ob_wr_en     = ob_wr_en_q;
  assign bus.ob_din       = ob_din_q;

endmodule

`default_nettype wire

// File: tb/tb_host_rd_engine.sv
// ============================================================================
// tb_host_rd_engine
//   Directed bench for host_rd_engine: reset, basic readout, partial burst,
//   zero count, credit stall, abort, simultaneous events, async reset and
//   (with HOST_RD_RING_EN) ring addressing.
//   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_host_rd_engine;

  localparam int AW   = 29;
  localparam int DW   = 128;
  localparam int OBW  = 10;
  localparam int OUTW = 7;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            reset_clk;
  logic            readout_start;
  logic            readout_abort;
  logic [AW-1:0]   readout_addr;
  logic [CW-1:0]   readout_count;
  logic            readout_busy;
  logic            readout_complete;
  logic [OUTW-1:0] outstanding;
`ifdef HOST_RD_RING_EN
  logic [AW-1:0]   ring_base;
  logic [AW-1:0]   ring_limit;
`endif

  host_rd_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OB_CNT_W(OBW)) bus ();

  host_rd_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BYTES(16), .ADDR_INCR(8),
    .OB_DEPTH(512), .OB_MARGIN(8), .MAX_OUTSTANDING(64), .CNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .reset_clk        (reset_clk),
    .readout_start    (readout_start),
    .readout_abort    (readout_abort),
    .readout_addr     (readout_addr),
    .readout_count    (readout_count),
    .readout_busy     (readout_busy),
    .readout_complete (readout_complete),
    .outstanding      (outstanding),
`ifdef HOST_RD_RING_EN
    .ring_base        (ring_base),
    .ring_limit       (ring_limit),
`endif
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int            due;
    logic [DW-1:0] d;
  } pend_t;

  int vectors    = 0;
  int miscompares = 0;

  // Memory responder controls and bookkeeping
  bit            resp_en = 1'b0;
  bit            data_en = 1'b1;
  int            cyc = 0;
  pend_t         pend[$];
  // Monitor bookkeeping
  int            mcyc = 0;
  logic [AW-1:0] cmd_addr[$];
  logic [DW-1:0] wr_data[$];
  int            ack_cnt, wr_cnt, cmpl_cnt, cmpl_cyc, last_wr_cyc;
  int            max_out, credit_viol, cmpl_busy_bad, start_cyc;

  // Memory model: ack a presented command one cycle in, return its data
  // (the command address) five cycles after the ack
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (resp_en) begin
        if (bus.mem_rd_req && !bus.mem_rd_ack) begin
          bus.mem_rd_ack = 1'b1;
          cmd_addr.push_back(bus.mem_rd_addr);
          pend.push_back('{due: cyc + 5, d: DW'(bus.mem_rd_addr)});
        end else begin
          bus.mem_rd_ack = 1'b0;
        end
        if (data_en && pend.size() > 0 && pend[0].due <= cyc) begin
          bus.mem_rd_data_valid = 1'b1;
          bus.mem_rd_data       = pend[0].d;
          void'(pend.pop_front());
        end else begin
          bus.mem_rd_data_valid = 1'b0;
          bus.mem_rd_data       = '0;
        end
      end
    end
  end

  // Output monitor, sampled 1 ns after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (bus.mem_rd_ack === 1'b1) ack_cnt++;
      if (bus.ob_wr_en === 1'b1) begin
        wr_cnt++;
        wr_data.push_back(bus.ob_din);
        last_wr_cyc = mcyc;
      end
      if (readout_complete === 1'b1) begin
        cmpl_cnt++;
        cmpl_cyc = mcyc;
        if (readout_busy !== 1'b0) cmpl_busy_bad++;
      end
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (bus.mem_rd_req === 1'b1 &&
          !(int'(bus.ob_count) + int'(outstanding) + 8 < 512)) credit_viol++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    ack_cnt = 0; wr_cnt = 0; cmpl_cnt = 0; cmpl_cyc = -1; last_wr_cyc = -1;
    max_out = 0; credit_viol = 0; cmpl_busy_bad = 0;
    cmd_addr.delete(); wr_data.delete(); pend.delete();
  endtask

  task automatic start_readout(input logic [AW-1:0] a, input logic [CW-1:0] c);
    @(negedge clk);
    readout_addr  = a;
    readout_count = c;
    readout_start = 1'b1;
    @(posedge clk);
    #2;
    start_cyc = mcyc;
    @(negedge clk);
    readout_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (readout_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (readout_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", readout_busy); end
    vectors++; if (readout_complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete: got %b expected 0", readout_complete); end
    vectors++; if (bus.mem_rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", bus.mem_rd_req); end
    vectors++; if (bus.mem_rd_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", bus.mem_rd_addr); end
    vectors++; if (bus.ob_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b expected 0", bus.ob_wr_en); end
    vectors++; if (bus.ob_din !== '0) begin miscompares++; $display("FAIL reset_din: got %h expected 0", bus.ob_din); end
    vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    reset_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    logic [AW-1:0] got;
    logic [DW-1:0] gd;
    clear_stats();
    resp_en = 1'b1; data_en = 1'b1; bus.ob_count = '0;
    start_readout(29'h100, 32'd64);
    wait_idle(200, ok);
    repeat (4) @(negedge clk);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_idle: got %b expected 1", ok); end
    vectors++; if (ack_cnt !== 4) begin miscompares++; $display("FAIL basic_cmds: got %0d expected 4", ack_cnt); end
    for (int i = 0; i < 4; i++) begin
      got = (i < cmd_addr.size()) ? cmd_addr[i] : '1;
      vectors++; if (got !== AW'(32'h100 + 8 * i)) begin miscompares++; $display("FAIL basic_addr%0d: got %h expected %h", i, got, 32'h100 + 8 * i); end
    end
    vectors++; if (wr_cnt !== 4) begin miscompares++; $display("FAIL basic_wr: got %0d expected 4", wr_cnt); end
    gd = (wr_data.size() == 4) ? wr_data[3] : '1;
    vectors++; if (gd !== DW'(32'h118)) begin miscompares++; $display("FAIL basic_last_word: got %h expected 118", gd); end
    vectors++; if (cmpl_cnt !== 1) begin miscompares++; $display("FAIL basic_complete: got %0d expected 1", cmpl_cnt); end
    vectors++; if (cmpl_cyc !== last_wr_cyc + 1) begin miscompares++; $display("FAIL basic_complete_time: got %0d expected %0d", cmpl_cyc, last_wr_cyc + 1); end
    vectors++; if (cmpl_busy_bad !== 0) begin miscompares++; $display("FAIL basic_busy_drop: got %0d expected 0", cmpl_busy_bad); end
  endtask

  task automatic test_partial();
    bit ok;
    clear_stats();
    start_readout(29'h400, 32'd40);
    wait_idle(200, ok);
    repeat (4) @(negedge clk);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL partial_idle: got %b expected 1", ok); end
    vectors++; if (ack_cnt !== 3) begin miscompares++; $display("FAIL partial_cmds: got %0d expected 3", ack_cnt); end
    vectors++; if (wr_cnt !== 3) begin miscompares++; $display("FAIL partial_wr: got %0d expected 3", wr_cnt); end
    vectors++; if (cmpl_cnt !== 1) begin miscompares++; $display("FAIL partial_complete: got %0d expected 1", cmpl_cnt); end
  endtask

  task automatic test_zero_count();
    clear_stats();
    start_readout(29'h40, 32'd0);
    repeat (6) @(negedge clk);
    vectors++; if (ack_cnt !== 0) begin miscompares++; $display("FAIL zero_cmds: got %0d expected 0", ack_cnt); end
    vectors++; if (cmpl_cnt !== 1) begin miscompares++; $display("FAIL zero_complete: got %0d expected 1", cmpl_cnt); end
    vectors++; if (cmpl_cyc !== start_cyc + 2) begin miscompares++; $display("FAIL zero_latency: got %0d expected %0d", cmpl_cyc, start_cyc + 2); end
  endtask

  task automatic test_credit_stall();
    bit ok;
    clear_stats();
    data_en = 1'b0;
    bus.ob_count = OBW'(500);
    start_readout(29'h0, 32'd256);
    repeat (40) @(negedge clk);
    // 500+3+8=511 still admits a 4th command; 500+4+8=512 blocks the 5th
    vectors++; if (max_out !== 4) begin miscompares++; $display("FAIL stall_peak: got %0d expected 4", max_out); end
    vectors++; if (ack_cnt !== 4) begin miscompares++; $display("FAIL stall_cmds: got %0d expected 4", ack_cnt); end
    vectors++; if (credit_viol !== 0) begin miscompares++; $display("FAIL stall_req_no_credit: got %0d expected 0", credit_viol); end
    vectors++; if (bus.mem_rd_req !== 1'b0) begin miscompares++; $display("FAIL stall_req: got %b expected 0", bus.mem_rd_req); end
    bus.ob_count = '0;
    repeat (20) @(negedge clk);
    vectors++; if (!(ack_cnt > 4)) begin miscompares++; $display("FAIL stall_resume: got %0d expected >4", ack_cnt); end
    data_en = 1'b1;
    wait_idle(500, ok);
    repeat (4) @(negedge clk);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_idle: got %b expected 1", ok); end
    vectors++; if (ack_cnt !== 16 || wr_cnt !== 16) begin miscompares++; $display("FAIL stall_totals: got %0d/%0d expected 16/16", ack_cnt, wr_cnt); end
    vectors++; if (cmpl_cnt !== 1) begin miscompares++; $display("FAIL stall_complete: got %0d expected 1", cmpl_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    int n, wr_at, out_at;
    clear_stats();
    start_readout(29'h2000, 32'd1024);
    n = 0;
    while (ack_cnt < 10 && n < 200) begin @(negedge clk); n++; end
    vectors++; if (ack_cnt !== 10) begin miscompares++; $display("FAIL abort_ack10: got %0d expected 10", ack_cnt); end
    wr_at = wr_cnt; out_at = int'(outstanding);
    readout_abort = 1'b1;
    @(negedge clk);
    readout_abort = 1'b0;
    wait_idle(200, ok);
    repeat (6) @(negedge clk);
    vectors++; if (wr_at !== 7 || out_at !== 3) begin miscompares++; $display("FAIL abort_snapshot: got wr %0d out %0d expected wr 7 out 3", wr_at, out_at); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got %b expected 1", ok); end
    vectors++; if (ack_cnt !== 10) begin miscompares++; $display("FAIL abort_no_more_cmds: got %0d expected 10", ack_cnt); end
    vectors++; if (wr_cnt !== 10) begin miscompares++; $display("FAIL abort_forwarded: got %0d expected 10", wr_cnt); end
    vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL abort_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (cmpl_cnt !== 0) begin miscompares++; $display("FAIL abort_no_complete: got %0d expected 0", cmpl_cnt); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int n;
    clear_stats();
    resp_en = 1'b0;
    bus.mem_rd_ack = 1'b0; bus.mem_rd_data_valid = 1'b0; bus.mem_rd_data = '0;
    start_readout(29'h3000, 32'd1024);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (bus.mem_rd_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      bus.mem_rd_ack = 1'b1;
      @(negedge clk);
      bus.mem_rd_ack = 1'b0;
      @(negedge clk);
    end
    vectors++; if (outstanding !== OUTW'(5)) begin miscompares++; $display("FAIL simul_pre: got %0d expected 5", outstanding); end
    n = 0;
    while (bus.mem_rd_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bus.mem_rd_ack = 1'b1;
    bus.mem_rd_data_valid = 1'b1;
    bus.mem_rd_data = DW'(32'hABCD);
    @(negedge clk);
    bus.mem_rd_ack = 1'b0;
    bus.mem_rd_data_valid = 1'b0;
    bus.mem_rd_data = '0;
    vectors++; if (outstanding !== OUTW'(5)) begin miscompares++; $display("FAIL simul_net0: got %0d expected 5", outstanding); end
    vectors++; if (bus.ob_wr_en !== 1'b1 || bus.ob_din !== DW'(32'hABCD)) begin miscompares++; $display("FAIL simul_forward: got %b/%h expected 1/abcd", bus.ob_wr_en, bus.ob_din); end
    readout_addr  = 29'h5555;
    readout_start = 1'b1;
    @(negedge clk);
    readout_start = 1'b0;
    @(negedge clk);
    vectors++; if (bus.mem_rd_addr !== 29'h3030) begin miscompares++; $display("FAIL busy_start_addr: got %h expected 3030", bus.mem_rd_addr); end
    vectors++; if (readout_busy !== 1'b1) begin miscompares++; $display("FAIL busy_start_busy: got %b expected 1", readout_busy); end
    readout_abort = 1'b1;
    @(negedge clk);
    readout_abort = 1'b0;
    vectors++; if (bus.mem_rd_req !== 1'b0) begin miscompares++; $display("FAIL simul_abort_req: got %b expected 0", bus.mem_rd_req); end
    bus.mem_rd_data_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.mem_rd_data_valid = 1'b0;
    wait_idle(20, ok);
    vectors++; if (ok !== 1'b1 || outstanding !== '0) begin miscompares++; $display("FAIL simul_drain: got idle %b out %0d expected 1/0", ok, outstanding); end
    bus.mem_rd_data_valid = 1'b1;
    @(negedge clk);
    bus.mem_rd_data_valid = 1'b0;
    vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL underflow: got %0d expected 0", outstanding); end
    vectors++; if (bus.ob_wr_en !== 1'b1) begin miscompares++; $display("FAIL idle_forward: got %b expected 1", bus.ob_wr_en); end
    repeat (3) @(negedge clk);
    vectors++; if (cmpl_cnt !== 0) begin miscompares++; $display("FAIL simul_no_complete: got %0d expected 0", cmpl_cnt); end
    resp_en = 1'b1;
  endtask

  task automatic test_async_reset();
    int n;
    clear_stats();
    start_readout(29'h700, 32'd1024);
    n = 0;
    while (ack_cnt < 3 && n < 100) begin @(negedge clk); n++; end
    #2;
    reset_clk = 1'b1;
    #1;
    vectors++; if (readout_busy !== 1'b0 || bus.mem_rd_req !== 1'b0) begin miscompares++; $display("FAIL areset_ctrl: got busy %b req %b expected 0/0", readout_busy, bus.mem_rd_req); end
    vectors++; if (bus.mem_rd_addr !== '0 || outstanding !== '0) begin miscompares++; $display("FAIL areset_state: got addr %h out %0d expected 0/0", bus.mem_rd_addr, outstanding); end
    resp_en = 1'b0;
    bus.mem_rd_ack = 1'b0; bus.mem_rd_data_valid = 1'b0; bus.mem_rd_data = '0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.ob_wr_en !== 1'b0 || bus.ob_din !== '0) begin miscompares++; $display("FAIL areset_data: got %b/%h expected 0/0", bus.ob_wr_en, bus.ob_din); end
    reset_clk = 1'b0;
    pend.delete();
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef HOST_RD_RING_EN
  task automatic test_ring();
    bit ok;
    logic [AW-1:0] got;
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 29'h1018; exp_a[1] = 29'h1000; exp_a[2] = 29'h1008;
    clear_stats();
    ring_base = 29'h1000; ring_limit = 29'h1020;
    start_readout(29'h1018, 32'd48);
    wait_idle(200, ok);
    vectors++; if (ok !== 1'b1 || ack_cnt !== 3) begin miscompares++; $display("FAIL ring_cmds: got idle %b cmds %0d expected 1/3", ok, ack_cnt); end
    for (int i = 0; i < 3; i++) begin
      got = (i < cmd_addr.size()) ? cmd_addr[i] : '1;
      vectors++; if (got !== exp_a[i]) begin miscompares++; $display("FAIL ring_addr%0d: got %h expected %h", i, got, exp_a[i]); end
    end
  endtask
`endif

  initial begin
    reset_clk = 1'b1;
    readout_start = 1'b0; readout_abort = 1'b0;
    readout_addr = '0; readout_count = '0;
    bus.mem_rd_ack = 1'b0; bus.mem_rd_data_valid = 1'b0; bus.mem_rd_data = '0;
    bus.ob_count = '0;
`ifdef HOST_RD_RING_EN
    ring_base = '0; ring_limit = '1;
`endif
    clear_stats();
    test_reset();
    test_basic();
    test_partial();
    test_zero_count();
    test_credit_stall();
    test_abort();
    test_simultaneous();
    test_async_reset();
`ifdef HOST_RD_RING_EN
    test_ring();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
